// File: rtl/spi_sensor_responder_pkg.sv
// Shared definitions for the SPI sensor responder: FSM states, command
// byte layout, register map and the writable-address rule.
package spi_sensor_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } spi_state_t;

  // Command byte layout
  localparam int CMD_RW_BIT = 7;  // 1 = read
  localparam int CMD_MB_BIT = 6;  // 1 = auto-increment address

  // Register map
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_THRESH_TAP  = 6'h1D;
  localparam logic [5:0] ADDR_TAP_AXES    = 6'h2A;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
  localparam logic [5:0] ADDR_FIFO_CTL    = 6'h38;

  // Mode bits and fixed values
  localparam int         MEASURE_BIT = 3;
  localparam logic [7:0] DATA_READY  = 8'h80;
  localparam logic [7:0] BW_RATE_RST = 8'h0A;

  // Addresses backed by storage that a write frame may update
  function automatic logic is_writable(input logic [5:0] addr);
    return (addr >= ADDR_THRESH_TAP && addr <= ADDR_TAP_AXES) ||
           (addr >= ADDR_BW_RATE    && addr <= ADDR_INT_MAP)  ||
           (addr == ADDR_DATA_FORMAT) || (addr == ADDR_FIFO_CTL);
  endfunction

endpackage

// File: rtl/spi_sensor_responder_if.sv
// Four-wire SPI bus plus the responder's SDO drive enable.
interface spi_sensor_responder_if;
  logic iSPI_SCLK;
  logic iSPI_CSN;
  logic iSPI_SDI;
  logic oSPI_SDO;
  logic oSDO_EN;

  modport master (output iSPI_SCLK, iSPI_CSN, iSPI_SDI, input oSPI_SDO, oSDO_EN);
  modport slave  (input iSPI_SCLK, iSPI_CSN, iSPI_SDI, output oSPI_SDO, oSDO_EN);
endinterface

// File: rtl/spi_sensor_responder_sync_edge.sv
// Two-flop synchronizer for one asynchronous input with level, rise and
// fall outputs in the iSPI_CLK domain.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic iSPI_CLK,
  input  logic iRSTN,
  input  logic iD,
  output logic oLEVEL,
  output logic oRISE,
  output logic oFALL
);

  // [0],[1] form the synchronizer; [2] holds the previous level for edge detect
  logic [2:0] sync_q;

  // Shift the input through the synchronizer and history flop
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value.
    if (!iRSTN) sync_q <= {3{RST_VAL}};
    else        sync_q <= {sync_q[1:0], iD};
  end

  assign oLEVEL = sync_q[1];
  assign oRISE  = sync_q[1] & ~sync_q[2];
  assign oFALL  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_sensor_responder.sv
// SPI mode-3 register responder for a 3-axis sensor: command/data framing,
// register file, axis snapshot and single-cycle write notification.
module spi_sensor_responder
  import spi_sensor_responder_pkg::*;
#(
  parameter logic [7:0] DEVID_VAL = 8'hE5,
  parameter int         SO_DataL  = 15
) (
  input  logic                  iSPI_CLK,
  input  logic                  iRSTN,
  spi_sensor_responder_if.slave spi,
  input  logic signed [SO_DataL:0] iDATA_X,
  input  logic signed [SO_DataL:0] iDATA_Y,
  input  logic signed [SO_DataL:0] iDATA_Z,
  output logic                  oREG_WE,
  output logic [5:0]            oREG_ADDR,
  output logic [7:0]            oREG_WDATA,
  output logic                  oMEASURE
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic csn_lvl, csn_rise, csn_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  // SCLK idles high in mode 3. CSN resets low so that a reset released
  // mid-frame never sees a falling edge until the initiator starts a new frame.
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .iD(spi.iSPI_SCLK),
    .oLEVEL(sclk_lvl), .oRISE(sclk_rise), .oFALL(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_csn (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .iD(spi.iSPI_CSN),
    .oLEVEL(csn_lvl), .oRISE(csn_rise), .oFALL(csn_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
    .iSPI_CLK(iSPI_CLK), .iRSTN(iRSTN), .iD(spi.iSPI_SDI),
    .oLEVEL(sdi_lvl), .oRISE(sdi_rise), .oFALL(sdi_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_lvl, csn_lvl, sdi_rise, sdi_fall};

  spi_state_t state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [6:0] shift_out;
  logic       cmd_rw, cmd_mb;
  logic [5:0] cur_addr;
  logic       sdo_q, sdo_en_q;
  logic [7:0] regs [64];
  logic signed [SO_DataL:0] shadow_x, shadow_y, shadow_z;

  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [47:0] shadow_all;
  logic [2:0]  sh_idx;

  assign rx_byte    = {shift_in, sdi_lvl};
  assign shadow_all = {16'(shadow_z), 16'(shadow_y), 16'(shadow_x)};
  assign sh_idx     = 3'(cur_addr - ADDR_DATAX0);
  assign oMEASURE   = regs[ADDR_POWER_CTL][MEASURE_BIT];
  assign spi.oSPI_SDO = sdo_q;
  assign spi.oSDO_EN  = sdo_en_q;

  // Read-data mux for the current address
  always_comb begin
    // NOTE: default first so every path assigns rd_byte and no latch is inferred.
    rd_byte = 8'h00;
    if (cur_addr == ADDR_DEVID)
      rd_byte = DEVID_VAL;
    else if (cur_addr == ADDR_INT_SOURCE)
      rd_byte = oMEASURE ? DATA_READY : 8'h00;
    else if (cur_addr >= ADDR_DATAX0 && cur_addr <= ADDR_DATAZ1)
      rd_byte = shadow_all[{sh_idx, 3'b000} +: 8];
    else if (is_writable(cur_addr))
      rd_byte = regs[cur_addr];
  end

  // Frame FSM, shift registers, register file and axis snapshot
  always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      cmd_rw     <= 1'b0;
      cmd_mb     <= 1'b0;
      cur_addr   <= '0;
      sdo_q      <= 1'b0;
      sdo_en_q   <= 1'b0;
      oREG_WE    <= 1'b0;
      oREG_ADDR  <= '0;
      oREG_WDATA <= '0;
      shadow_x   <= '0;
      shadow_y   <= '0;
      shadow_z   <= '0;
      // NOTE: the register file is a handful of flops with defined reset values,
      // not a RAM, so resetting it is intended.
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[ADDR_BW_RATE] <= BW_RATE_RST;
    end else begin
      oREG_WE <= 1'b0;
      if (csn_fall) begin
        shadow_x <= iDATA_X;
        shadow_y <= iDATA_Y;
        shadow_z <= iDATA_Z;
      end
      if (csn_rise) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        sdo_q    <= 1'b0;
        sdo_en_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (csn_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                cmd_rw   <= rx_byte[CMD_RW_BIT];
                cmd_mb   <= rx_byte[CMD_MB_BIT];
                cur_addr <= rx_byte[5:0];
                state    <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall && cmd_rw) begin
              if (bit_cnt == 3'd0) begin
                sdo_q     <= rd_byte[7];
                shift_out <= rd_byte[6:0];
                sdo_en_q  <= 1'b1;
              end else begin
                sdo_q     <= shift_out[6];
                shift_out <= {shift_out[5:0], 1'b0};
              end
            end
            if (sclk_rise) begin
              shift_in <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!cmd_rw && is_writable(cur_addr)) begin
                  regs[cur_addr] <= rx_byte;
                  oREG_WE        <= 1'b1;
                  oREG_ADDR      <= cur_addr;
                  oREG_WDATA     <= rx_byte;
                end
                if (cmd_mb) cur_addr <= cur_addr + 6'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Scoreboard bench for spi_sensor_responder: a register-map model predicts
// read bytes and write notifications; monitors compare what the DUT presents.
module tb_spi_sensor_responder;

  localparam int HP = 60;  // SCLK half period, 6 system clocks

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sensor_responder_if spi_if ();

  logic signed [15:0] data_x, data_y, data_z;
  logic       reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       measure;

  spi_sensor_responder dut (
    .iSPI_CLK  (clk),
    .iRSTN     (rst_n),
    .spi       (spi_if),
    .iDATA_X   (data_x),
    .iDATA_Y   (data_y),
    .iDATA_Z   (data_z),
    .oREG_WE   (reg_we),
    .oREG_ADDR (reg_addr),
    .oREG_WDATA(reg_wdata),
    .oMEASURE  (measure)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_rd_q[$];
  logic [13:0] exp_wr_q[$];
  logic [7:0]  model_regs [64];
  logic [7:0]  model_shadow [6];
  logic [7:0]  wbuf [8];
  int          frame_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_writable(input logic [5:0] a);
    int v;
    v = int'(a);
    return (v >= 'h1D && v <= 'h2A) || (v >= 'h2C && v <= 'h2F) || v == 'h31 || v == 'h38;
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    int v;
    v = int'(a);
    if (v == 0) return 8'hE5;
    if (v == 'h30) return model_regs['h2D][3] ? 8'h80 : 8'h00;
    if (v >= 'h32 && v <= 'h37) return model_shadow[v - 'h32];
    if (model_writable(a)) return model_regs[v];
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model_regs[i] = 8'h00;
    model_regs['h2C] = 8'h0A;
    for (int i = 0; i < 6; i++) model_shadow[i] = 8'h00;
  endtask

  // ---------------- monitors ----------------
  // Write notifications: every oREG_WE cycle must match a predicted write.
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && reg_we) begin
        if (exp_wr_q.size() == 0) check("reg_we_unexpected", reg_we, 1'b0);
        else begin
          e = exp_wr_q.pop_front();
          check("reg_addr", reg_addr, e[13:8]);
          check("reg_wdata", reg_wdata, e[7:0]);
        end
      end
    end
  end

  // Read data: assemble SDO bits sampled as SCLK rises while SDO is enabled.
  initial begin
    int seen = -1;
    int n = 0;
    logic [7:0] sh = 8'h00;
    forever begin
      @(posedge spi_if.iSPI_SCLK);
      if (frame_id != seen) begin
        seen = frame_id;
        n = 0;
      end
      if (rst_n && !spi_if.iSPI_CSN && spi_if.oSDO_EN) begin
        sh = {sh[6:0], spi_if.oSPI_SDO};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_rd_q.size() == 0) check("sdo_en_unexpected", spi_if.oSDO_EN, 1'b0);
          else check("sdo_byte", sh, exp_rd_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One frame: command byte then data_bits bits taken from wbuf. Ends with
  // CSN rising, or with reset asserted (CSN left low) when do_reset is set.
  task automatic spi_frame(input logic [7:0] cmd, input int nbytes, input int data_bits,
                           input logic do_reset);
    logic [5:0] a;
    logic       rd;
    logic [7:0] byte_v;
    a  = cmd[5:0];
    rd = cmd[7];
    frame_id++;
    model_shadow[0] = data_x[7:0];  model_shadow[1] = data_x[15:8];
    model_shadow[2] = data_y[7:0];  model_shadow[3] = data_y[15:8];
    model_shadow[4] = data_z[7:0];  model_shadow[5] = data_z[15:8];
    for (int i = 0; i < nbytes; i++) begin
      if ((i + 1) * 8 <= data_bits) begin
        if (rd) exp_rd_q.push_back(model_read(a));
        else if (model_writable(a)) begin
          exp_wr_q.push_back({a, wbuf[i]});
          model_regs[int'(a)] = wbuf[i];
        end
      end
      if (cmd[6]) a = a + 6'd1;
    end
    @(negedge clk);
    spi_if.iSPI_CSN = 1'b0;
    #(HP);
    for (int b = 0; b < 8 + data_bits; b++) begin
      byte_v = (b < 8) ? cmd : wbuf[(b - 8) / 8];
      spi_if.iSPI_SCLK = 1'b0;
      spi_if.iSPI_SDI  = byte_v[7 - (b % 8)];
      #(HP);
      spi_if.iSPI_SCLK = 1'b1;
      check("sdo_en_phase", spi_if.oSDO_EN, rd && (b >= 8));
      #(HP);
    end
    if (do_reset) begin
      rst_n = 1'b0;
      #1;
      check("rst_sdo_en", spi_if.oSDO_EN, 1'b0);
      check("rst_sdo", spi_if.oSPI_SDO, 1'b0);
      check("rst_we", reg_we, 1'b0);
      model_reset();
    end else begin
      spi_if.iSPI_CSN = 1'b1;
      spi_if.iSPI_SDI = 1'b0;
      #(2 * HP);
      check("sdo_en_after_frame", spi_if.oSDO_EN, 1'b0);
      check("measure", measure, model_regs['h2D][3]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] cmd;
    spi_if.iSPI_CSN  = 1'b1;
    spi_if.iSPI_SCLK = 1'b1;
    spi_if.iSPI_SDI  = 1'b0;
    data_x = '0; data_y = '0; data_z = '0;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h00;
    model_reset();

    #23;
    check("reset_sdo_en", spi_if.oSDO_EN, 1'b0);
    check("reset_sdo", spi_if.oSPI_SDO, 1'b0);
    check("reset_we", reg_we, 1'b0);
    check("reset_addr", reg_addr, 6'h00);
    check("reset_wdata", reg_wdata, 8'h00);
    check("reset_measure", measure, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #(2 * HP);

    // Device id read with one dummy byte
    wbuf[0] = 8'h5A;
    spi_frame(8'h80, 1, 8, 1'b0);

    // Enter measure mode, then DATA_READY is visible
    wbuf[0] = 8'h08;
    spi_frame(8'h2D, 1, 8, 1'b0);
    spi_frame(8'hB0, 1, 8, 1'b0);

    // Axis burst read; X changes mid-frame and must not leak into the output
    data_x = 16'sh1234; data_y = 16'shFFCE; data_z = 16'sh0100;
    fork
      spi_frame(8'hF2, 6, 48, 1'b0);
      begin #(4 * HP); data_x = 16'sh7E5A; end
    join

    // Address wrap 0x3F -> 0x00
    spi_frame(8'hFF, 2, 16, 1'b0);

    // Aborted write after 5 data bits, then read back 0x31
    wbuf[0] = 8'hFF;
    spi_frame(8'h31, 1, 5, 1'b0);
    spi_frame(8'hB1, 1, 8, 1'b0);

    // Randomized frames
    for (int r = 0; r < 24; r++) begin
      data_x = 16'($urandom); data_y = 16'($urandom); data_z = 16'($urandom);
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      cmd[7] = 1'($urandom_range(0, 1));
      cmd[6] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) cmd[5:0] = 6'($urandom_range(0, 63));
      else cmd[5:0] = 6'($urandom_range('h1C, 'h39));
      begin
        int nb;
        nb = int'($urandom_range(1, 4));
        spi_frame(cmd, nb, nb * 8, 1'b0);
      end
    end

    // Reset asserted in the middle of a read; release while CSN is still low
    wbuf[0] = 8'h08;
    spi_frame(8'h2D, 1, 8, 1'b0);
    spi_frame(8'hAC, 1, 3, 1'b1);
    #(HP);
    rst_n = 1'b1;
    #(HP);
    @(negedge clk);
    for (int b = 0; b < 16; b++) begin
      spi_if.iSPI_SCLK = 1'b0;
      spi_if.iSPI_SDI  = 1'($urandom_range(0, 1));
      #(HP);
      spi_if.iSPI_SCLK = 1'b1;
      check("post_rst_sdo_en", spi_if.oSDO_EN, 1'b0);
      #(HP);
    end
    spi_if.iSPI_CSN = 1'b1;
    #(2 * HP);
    check("post_rst_measure", measure, 1'b0);
    wbuf[0] = 8'h00;
    spi_frame(8'hAC, 1, 8, 1'b0);
    spi_frame(8'hAD, 1, 8, 1'b0);

    #(4 * HP);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_sensor_responder.md
SPI_SENSOR_RESPONDER -- requirements
Module: spi_sensor_responder

Interface
REQ-001 SHALL have parameter DEVID_VAL, default 8'hE5, value returned at register 0x00.
REQ-002 SHALL have parameter SO_DataL, default 15, MSB index of each axis sample input.
REQ-003 SHALL have port iSPI_CLK, input, 1, system clock; one clock only.
REQ-004 SHALL have port iRSTN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iSPI_SCLK, input, 1, serial clock from the SPI initiator, asynchronous to iSPI_CLK.
REQ-006 SHALL have port iSPI_CSN, input, 1, chip select, active low.
REQ-007 SHALL have port iSPI_SDI, input, 1, initiator-to-responder serial data.
REQ-008 SHALL have port oSPI_SDO, output, 1, responder-to-initiator serial data.
REQ-009 SHALL have port oSDO_EN, output, 1, SDO drive enable, high only during read data bytes.
REQ-010 SHALL have ports iDATA_X, iDATA_Y, iDATA_Z, input, SO_DataL+1 each, signed axis samples.
REQ-011 SHALL have ports oREG_WE, output, 1, one-cycle pulse per committed write; oREG_ADDR, output, 6, written address; oREG_WDATA, output, 8, written data.
REQ-012 SHALL have port oMEASURE, output, 1, bit 3 of register 0x2D.

Function
REQ-013 SHALL synchronize iSPI_SCLK, iSPI_CSN and iSPI_SDI through 2 flops, then edge-detect on iSPI_CLK; SCLK high and low phases of at least 4 iSPI_CLK cycles each are supported.
REQ-014 SHALL implement SPI mode 3: sample SDI on SCLK rising edge, update SDO on SCLK falling edge, MSB first.
REQ-015 SHALL use FSM states IDLE, CMD, DATA; IDLE->CMD on CSN fall, CMD->DATA after 8th rising edge, DATA->DATA per byte, any state->IDLE on CSN rise.
REQ-016 SHALL decode the command byte as bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = start address.
REQ-017 SHALL snapshot iDATA_X/Y/Z into shadow registers on the CSN falling edge; reads of 0x32..0x37 return the shadow as X[7:0], X[15:8], Y[7:0], Y[15:8], Z[7:0], Z[15:8].
REQ-018 SHALL have the shadow ignore input changes while CSN is low.
REQ-019 SHALL, on reads, load the addressed byte on the falling edge after the 8th bit of the previous byte and drive its MSB while oSDO_EN = 1.
REQ-020 SHALL commit writes only on the 8th rising edge of a data byte: register updated and oREG_WE pulsed for exactly one cycle with address and data.
REQ-021 SHALL, with MB = 1, increment the address after each data byte, wrapping 0x3F->0x00; with MB = 0, hold the address.
REQ-022 SHALL store writable registers 0x1D..0x2A and 0x2C..0x2F and 0x31 and 0x38; 0x00 is read-only DEVID_VAL; 0x30 and 0x32..0x37 are read-only; all others read 8'h00 and ignore writes.
REQ-023 SHALL, on CSN rise mid-byte, discard the partial byte with no write and no oREG_WE pulse, and return to IDLE.
REQ-024 SHALL ignore SCLK edges while CSN is high; oSDO_EN = 0 in IDLE, CMD and write frames.
REQ-025 SHALL give register 0x30 a value of 8'h80 (DATA_READY) whenever oMEASURE = 1, else 8'h00.

Reset
REQ-026 SHALL, on iRSTN low, asynchronously set FSM = IDLE, bit counter = 0, oSPI_SDO = 0, oSDO_EN = 0, oREG_WE = 0, oREG_ADDR = 0, oREG_WDATA = 0 and the shadow registers = 0.
REQ-027 SHALL, on iRSTN low, set all writable registers to 0 except 0x2C = 8'h0A, so that oMEASURE = 0.
REQ-028 SHALL, after reset is released mid-frame, stay in IDLE until the next CSN falling edge.

Structure
REQ-029 SHALL take register addresses (BW_RATE, POWER_CONTROL, DATA_FORMAT, X_LB, etc.) and mode-bit encodings from the shared include spi_param_v2.h; FSM state encodings also belong there.
REQ-030 SHALL contain one sub-module, spi_sync_edge, which synchronizes one input and provides its level, rise and fall outputs, instantiated three times.

Verification
REQ-031 SHALL cover: write frame 0x2D,0x08 -> oREG_WE pulse with addr 0x2D and data 0x08; oMEASURE = 1; read of 0x30 = 0x80.
REQ-032 SHALL cover: read 0x80 followed by a dummy byte -> SDO byte 0xE5, with oSDO_EN high only during the data byte.
REQ-033 SHALL cover: X=0x1234, Y=0xFFCE, Z=0x0100, multi-read 0xF2 plus 6 bytes -> 34 12 CE FF 00 01; X changed mid-frame -> output unchanged.
REQ-034 SHALL cover: multi-read 0xFF plus 2 bytes -> 0x00 then 0xE5 (address wrap).
REQ-035 SHALL cover: write 0x31 with CSN raised after 5 data bits -> no oREG_WE; 0x31 remains 0x00.
REQ-036 SHALL cover: iRSTN asserted mid-read -> oSDO_EN = 0 immediately and 0x2C reads 0x0A afterwards.
